fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width (word-addressed).
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode = instr[INSTR_W-1 -: 4].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  ADDR_W  fetch address, valid while imem_req=1.
REQ-007 SHALL have port imem_valid  input  1  memory response strobe, may be high in the same cycle as imem_req.
REQ-008 SHALL have port imem_rdata  input  INSTR_W  instruction word, valid with imem_valid.
REQ-009 SHALL have port stall  input  1  decode/control stage cannot accept the held instruction.
REQ-010 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-011 SHALL have port branch_target  input  ADDR_W  redirect address.
REQ-012 SHALL have ports instr  output  INSTR_W, opcode  output  4, instr_pc  output  ADDR_W, and instr_valid  output  1, carrying the held instruction, its opcode field, its address and its qualifier.

Function
REQ-013 SHALL implement states IDLE, FETCH, ISSUE, FLUSH and, under FETCH_HALT_EN, HALT.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-015 FETCH SHALL drive imem_req=1 and imem_addr=pc, holding both stable until imem_valid.
REQ-016 imem_valid sampled in FETCH SHALL load instr<=imem_rdata and instr_pc<=pc, set pc<=pc+1 (modulo 2^ADDR_W, so all-ones wraps to 0), and go to ISSUE.
REQ-017 ISSUE SHALL drive instr_valid=1 and imem_req=0, and hold instr/instr_pc unchanged while stall=1.
REQ-018 ISSUE with stall=0 at an edge SHALL consume the instruction and go to FETCH; minimum throughput is one instruction per two cycles.
REQ-019 opcode SHALL always equal the top 4 bits of instr (combinational from the register).
REQ-020 branch_taken=1 at an edge in any non-IDLE state SHALL set pc<=branch_target, clear instr_valid and go to FLUSH, overriding simultaneous imem_valid and stall.
REQ-021 FLUSH SHALL last one cycle with imem_req=0, ignore imem_valid (stale response discarded), then go to FETCH at the target.
REQ-022 imem_valid outside FETCH SHALL be ignored.
REQ-023 instr_valid SHALL be 1 only in ISSUE.

Reset
REQ-024 rst_n=0 SHALL immediately, without clk, force state IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=0.
REQ-025 Reset asserted mid-fetch or mid-stall SHALL abandon the transaction; the first request after release SHALL be address 0.

Configuration
REQ-026 Macro FETCH_HALT_EN, when defined, SHALL make entry to ISSUE with opcode 4'b1111 go to HALT instead of FETCH once consumed (stall=0); HALT holds imem_req=0 and instr_valid=0, ignores branch_taken, and exits only by reset.
REQ-027 Without FETCH_HALT_EN, opcode 4'b1111 SHALL be fetched and issued like any other opcode and the HALT state SHALL not exist.

Verification
REQ-028 Reset release, memory with 1-cycle latency, stall=0 -> imem_addr sequence 0,1,2,3, with instr_valid pulsing every second cycle and instr_pc matching each address.
REQ-029 stall=1 for 5 cycles while in ISSUE -> instr, instr_pc and opcode stable for all 5 cycles, imem_req=0, and the next request follows stall release.
REQ-030 branch_taken=1, branch_target=8'h40 coincident with imem_valid -> response discarded, 1-cycle FLUSH, next imem_addr=8'h40.
REQ-031 pc=8'hFF fetched -> next imem_addr=8'h00.
REQ-032 rst_n pulsed low for 3 ps between clock edges while imem_req=1 -> all outputs 0 at once, and the fetch restarts at 0 after release.
REQ-033 With FETCH_HALT_EN defined, fetching 16'hF000 -> issued once, then imem_req remains 0 despite branch_taken=1, until reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time, holds it for decode, redirects on branch.
// Optional macro FETCH_HALT_EN adds a terminal HALT state entered after issuing opcode 4'b1111.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | imem_req=1 at pc, waiting for imem_valid
// ISSUE | instruction held for decode, instr_valid=1
// FLUSH | one dead cycle after a redirect, stale response dropped
// HALT  | (FETCH_HALT_EN only) stopped until reset
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, FLUSH, HALT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, FLUSH} state_t;
`endif

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    ipc_q;
    logic                 halted;
    logic                 redirect;
    logic                 load;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

    // A redirect wins over any response or stall arriving in the same cycle.
    assign redirect = branch_taken && (state_q != IDLE) && !halted;
    assign load     = (state_q == FETCH) && imem_valid && !branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (redirect)   state_d = FLUSH;
                else if (load)  state_d = ISSUE;
            end
            ISSUE: begin
                if (redirect) begin
                    state_d = FLUSH;
                end else if (!stall) begin
`ifdef FETCH_HALT_EN
                    state_d = (opcode == 4'b1111) ? HALT : FETCH;
`else
                    state_d = FETCH;
`endif
                end
            end
            FLUSH: state_d = redirect ? FLUSH : FETCH;
`ifdef FETCH_HALT_EN
            HALT:  state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else if (redirect) begin
            pc_q <= branch_target;
        end else if (load) begin
            instr_q <= imem_rdata;
            ipc_q   <= pc_q;
            pc_q    <= pc_q + ADDR_W'(1);
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign opcode      = instr_q[INSTR_W-1 -: 4];

endmodule
